phase_sequencer: RTL and testbench

Controller that drives the preset/load side of the 4-bit presettable down counter and watches its count output, stepping through four timed phases. Each phase length is loaded into the counter. When the counter reaches 0000, the block advances to the next phase and reloads. It replaces the counter's self-generated reload pulse with an explicit, checked handshake, and adds load verification and a stall watchdog.

---
 rtl/phase_sequencer.sv | 114 +++++++++++
 tb/tb_phase_sequencer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sequencer.sv
// Drives the preset/load side of a 4-bit presettable down counter through four timed phases,
// verifying each load and guarding each phase with a stall watchdog.
module phase_sequencer #(
  parameter logic [3:0]  DUR0    = 4'd6,
  parameter logic [3:0]  DUR1    = 4'd5,
  parameter logic [3:0]  DUR2    = 4'd3,
  parameter logic [3:0]  DUR3    = 4'd1,
  parameter bit          LOOP    = 1'b1,
  parameter int unsigned TIMEOUT = 20
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic [3:0] count_in,
  output logic [3:0] preset,
  output logic       load,
  output logic [1:0] phase,
  output logic       phase_done,
  output logic       busy,
  output logic       err
);

  typedef enum logic [2:0] {IDLE, LOAD, VERIFY, RUN, ERROR} state_t;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] watchdog;

  function automatic logic [3:0] dur(input logic [1:0] p);
    case (p)
      2'd0:    return DUR0;
      2'd1:    return DUR1;
      2'd2:    return DUR2;
      default: return DUR3;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state      <= IDLE;
      phase      <= '0;
      preset     <= '0;
      load       <= 1'b0;
      phase_done <= 1'b0;
      busy       <= 1'b0;
      err        <= 1'b0;
      watchdog   <= '0;
    end else begin
      load       <= 1'b0;
      phase_done <= 1'b0;
      // stop outranks everything in the active states, including a coincident zero
      if (stop && (state == LOAD || state == VERIFY || state == RUN)) begin
        state <= IDLE;
        phase <= '0;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start && !stop) begin
              state  <= LOAD;
              phase  <= '0;
              preset <= dur(2'd0);
              load   <= 1'b1;
              busy   <= 1'b1;
            end
          end
          LOAD: state <= VERIFY;
          VERIFY: begin
            if (count_in == preset) begin
              state    <= RUN;
              watchdog <= '0;
            end else begin
              state <= ERROR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
          RUN: begin
            watchdog <= watchdog + 8'd1;
            if (count_in == 4'd0) begin
              phase_done <= 1'b1;
              if (phase == 2'd3 && !LOOP) begin
                state <= IDLE;
                phase <= '0;
                busy  <= 1'b0;
              end else begin
                state  <= LOAD;
                phase  <= phase + 2'd1;
                preset <= dur(phase + 2'd1);
                load   <= 1'b1;
              end
            end else if (watchdog + 8'd1 == TMO) begin
              state <= ERROR;
              busy  <= 1'b0;
              err   <= 1'b1;
            end
          end
          ERROR: begin
            if (clear) begin
              state <= IDLE;
              phase <= '0;
              err   <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench for phase_sequencer: a looping and a one-shot instance, each fed by a counter model,
// checked every cycle against a phase-position reference model plus directed vectors.
module tb_phase_sequencer;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset_n = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [3:0] cnt_a, cnt_b, preset_a, preset_b;
  logic [1:0] phase_a, phase_b;
  logic       load_a, load_b, pd_a, pd_b, busy_a, busy_b, err_a, err_b;
  logic [9:0] out_a, out_b;

  localparam logic [15:0] DURS_A = {4'd1, 4'd3, 4'd5, 4'd6};
  localparam logic [15:0] DURS_B = {4'd3, 4'd1, 4'd2, 4'd0};

  phase_sequencer #(.LOOP(1'b1), .TIMEOUT(20)) dut_a (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
    .count_in(cnt_a), .preset(preset_a), .load(load_a), .phase(phase_a),
    .phase_done(pd_a), .busy(busy_a), .err(err_a));

  phase_sequencer #(.DUR0(4'd0), .DUR1(4'd2), .DUR2(4'd1), .DUR3(4'd3),
                    .LOOP(1'b0), .TIMEOUT(7)) dut_b (
    .clock(clock), .reset_n(reset_n), .start(start), .stop(stop), .clear(clear),
    .count_in(cnt_b), .preset(preset_b), .load(load_b), .phase(phase_b),
    .phase_done(pd_b), .busy(busy_b), .err(err_b));

  assign out_a = {phase_a, preset_a, load_a, pd_a, busy_a, err_a};
  assign out_b = {phase_b, preset_b, load_b, pd_b, busy_b, err_b};

  // mode: 0 idle, 1 sequencing, 2 faulted; pos counts cycles since the phase's load cycle
  typedef struct { int mode; int phase; int pos; logic [3:0] preset; bit pdone; } ref_t;
  typedef struct { logic [3:0] q; bit hold; bit ignore; bit ovr; logic [3:0] ovr_val; } ctr_t;
  typedef struct { bit rst_n; bit st; bit sp; bit cl; logic [3:0] cnt; logic [9:0] exp; } vec_t;

  ref_t ra = '{0, 0, 0, 4'd0, 1'b0}, rb = '{0, 0, 0, 4'd0, 1'b0};
  ctr_t ca = '{4'd0, 1'b0, 1'b0, 1'b0, 4'd0}, cb = '{4'd0, 1'b0, 1'b0, 1'b0, 4'd0};

  assign cnt_a = ca.ovr ? ca.ovr_val : ca.q;
  assign cnt_b = cb.ovr ? cb.ovr_val : cb.q;

  int nvec = 0, nerr = 0, cyc = 0;
  int pd_stamps[$];
  int pd_phases[$];
  int loads_a = 0, pds_b = 0;

  function automatic ref_t ref_step(ref_t s, logic [15:0] durs, bit loop, int tmo,
                                    bit rst, bit st, bit sp, bit cl, logic [3:0] cin);
    ref_t n = s;
    n.pdone = 1'b0;
    if (!rst) begin
      n.mode = 0; n.phase = 0; n.pos = 0; n.preset = 4'd0;
      return n;
    end
    case (s.mode)
      0: if (st && !sp) begin
        n.mode = 1; n.phase = 0; n.pos = 0; n.preset = durs[3:0];
      end
      1: begin
        if (sp) begin
          n.mode = 0; n.phase = 0;
        end else if (s.pos == 0) begin
          n.pos = 1;
        end else if (s.pos == 1) begin
          if (cin == s.preset) n.pos = 2; else n.mode = 2;
        end else if (cin == 4'd0) begin
          n.pdone = 1'b1;
          if (s.phase == 3 && !loop) begin
            n.mode = 0; n.phase = 0;
          end else begin
            n.phase = (s.phase + 1) % 4;
            n.pos = 0;
            n.preset = durs[n.phase*4 +: 4];
          end
        end else if (s.pos - 1 >= tmo) begin
          n.mode = 2;
        end else begin
          n.pos = s.pos + 1;
        end
      end
      2: if (cl) begin
        n.mode = 0; n.phase = 0;
      end
      default: ;
    endcase
    return n;
  endfunction

  function automatic logic [9:0] ref_out(ref_t s);
    logic [1:0] ph = 2'(s.phase);
    return {ph, s.preset, (s.mode == 1 && s.pos == 0), s.pdone, (s.mode == 1), (s.mode == 2)};
  endfunction

  // Counter takes one cycle to latch the preset, holds it one more, then counts down to 0.
  function automatic ctr_t ctr_step(ctr_t c, ref_t r);
    ctr_t n = c;
    if (r.mode == 1 && r.pos == 0 && !c.ignore) begin
      n.q = r.preset; n.hold = 1'b1;
    end else if (c.hold) begin
      n.hold = 1'b0;
    end else if (c.q != 4'd0 && !c.ignore) begin
      n.q = c.q - 4'd1;
    end
    return n;
  endfunction

  function automatic logic [9:0] o(int ph, int pre, bit ld, bit pd, bit bz, bit er);
    logic [1:0] p2 = 2'(ph);
    logic [3:0] p4 = 4'(pre);
    return {p2, p4, ld, pd, bz, er};
  endfunction

  task automatic check(string name, logic [9:0] act, logic [9:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cycle %0d: actual {phase,preset,load,done,busy,err}=%03h required=%03h",
               name, cyc, act, exp);
    end
  endtask

  task automatic check_val(string name, int act, int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s @cycle %0d: actual=%0d required=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] cia, cib;
    @(posedge clock);
    #1;
    cia = cnt_a;
    cib = cnt_b;
    ca = ctr_step(ca, ra);
    cb = ctr_step(cb, rb);
    ra = ref_step(ra, DURS_A, 1'b1, 20, reset_n, start, stop, clear, cia);
    rb = ref_step(rb, DURS_B, 1'b0, 7, reset_n, start, stop, clear, cib);
    cyc++;
    check("model_a", out_a, ref_out(ra));
    check("model_b", out_b, ref_out(rb));
    if (pd_a) begin
      pd_stamps.push_back(cyc);
      pd_phases.push_back(int'(phase_a));
    end
    if (load_a) loads_a++;
    if (pd_b) pds_b++;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  vec_t tbl[16];
  int   t0;
  bit   found;
  int   exp_gap[8] = '{9, 8, 6, 4, 9, 8, 6, 4};
  int   exp_ph[8]  = '{1, 2, 3, 0, 1, 2, 3, 0};

  initial begin
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, o(0, 0, 0, 0, 0, 0)};
    tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'h0, o(0, 0, 0, 0, 0, 0)};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, o(0, 6, 1, 0, 1, 0)};
    tbl[3]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, o(0, 6, 0, 0, 1, 0)};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'hF, o(0, 6, 0, 0, 0, 1)};
    tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'hF, o(0, 6, 0, 0, 0, 1)};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'hF, o(0, 6, 0, 0, 0, 0)};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h6, o(0, 6, 1, 0, 1, 0)};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h6, o(0, 6, 0, 0, 1, 0)};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h6, o(0, 6, 0, 0, 1, 0)};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, o(1, 5, 1, 1, 1, 0)};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h0, o(1, 5, 0, 0, 1, 0)};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 1'b0, 4'h5, o(1, 5, 0, 0, 1, 0)};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'h0, o(0, 5, 0, 0, 0, 0)};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 4'h0, o(0, 6, 1, 0, 1, 0)};
    tbl[15] = '{1'b0, 1'b0, 1'b0, 1'b0, 4'h0, o(0, 0, 0, 0, 0, 0)};

    ca.ovr = 1'b1;
    for (int i = 0; i < 16; i++) begin
      reset_n = tbl[i].rst_n; start = tbl[i].st; stop = tbl[i].sp; clear = tbl[i].cl;
      ca.ovr_val = tbl[i].cnt;
      tick();
      check($sformatf("table[%0d]", i), out_a, tbl[i].exp);
    end
    ca.ovr = 1'b0;

    // Nominal run: looping instance steps 6,5,3,1 repeatedly; one-shot instance stops after phase 3
    do_reset();
    pd_stamps.delete(); pd_phases.delete();
    loads_a = 0; pds_b = 0;
    start = 1'b1;
    tick();
    t0 = cyc;
    start = 1'b0;
    repeat (59) tick();
    check_val("nominal_pd_count", pd_stamps.size(), 8);
    for (int i = 0; i < 8 && i < pd_stamps.size(); i++) begin
      check_val($sformatf("nominal_gap[%0d]", i),
                pd_stamps[i] - ((i == 0) ? t0 : pd_stamps[i-1]), exp_gap[i]);
      check_val($sformatf("nominal_phase[%0d]", i), pd_phases[i], exp_ph[i]);
    end
    check_val("nominal_load_count", loads_a, 9);
    check_val("oneshot_pd_count", pds_b, 4);
    repeat (3) tick();
    check_val("oneshot_busy", int'(busy_b), 0);
    check_val("oneshot_phase", int'(phase_b), 0);

    // Reset in the middle of phase 2 with the counter showing 2
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (ra.mode == 1 && ra.phase == 2 && ra.pos >= 2 && cnt_a == 4'd2) found = 1'b1;
      else tick();
    end
    if (!found) begin
      nvec++; nerr++;
      $display("FAIL midrun_wait @cycle %0d: actual=not reached required=phase 2 count 2", cyc);
    end
    reset_n = 1'b0;
    tick();
    check("midrun_reset", out_a, 10'h000);
    reset_n = 1'b1;

    // Counter ignores the load and stays at F
    ca.q = 4'hF; ca.ignore = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_val("mismatch_err_early", int'(err_a), 0);
    tick();
    check_val("mismatch_err", int'(err_a), 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_val("mismatch_clear_err", int'(err_a), 0);
    check_val("mismatch_clear_busy", int'(busy_a), 0);
    ca.ignore = 1'b0;

    // Stall at 4 after VERIFY: error on the 20th RUN cycle, or phase_done if zero arrives then
    for (int v = 0; v < 2; v++) begin
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      ca.ovr = 1'b1; ca.ovr_val = 4'd4;
      repeat (19) tick();
      check_val($sformatf("stall%0d_err_19", v), int'(err_a), 0);
      check_val($sformatf("stall%0d_busy_19", v), int'(busy_a), 1);
      ca.ovr_val = (v == 0) ? 4'd4 : 4'd0;
      tick();
      check_val($sformatf("stall%0d_err_20", v), int'(err_a), (v == 0) ? 1 : 0);
      check_val($sformatf("stall%0d_done_20", v), int'(pd_a), (v == 0) ? 0 : 1);
      ca.ovr = 1'b0;
    end

    // Randomized traffic including load faults and frozen counts
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      reset_n = ($urandom_range(0, 299) != 0);
      start = ($urandom_range(0, 5) == 0);
      stop = ($urandom_range(0, 49) == 0);
      clear = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 99) == 0) ca.ignore = !ca.ignore;
      if ($urandom_range(0, 99) == 0) cb.ignore = !cb.ignore;
      if ($urandom_range(0, 79) == 0) begin ca.ovr = !ca.ovr; ca.ovr_val = 4'($urandom_range(0, 15)); end
      if ($urandom_range(0, 79) == 0) begin cb.ovr = !cb.ovr; cb.ovr_val = 4'($urandom_range(0, 15)); end
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
